// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: horizontal/vertical counters, pixel-coordinate
// requests to an upstream source, and a delay line that aligns the returned
// RGB with sync and data-enable.
// Optional build macro VGA_TEST_PATTERN_EN replaces pix_* with an internal
// pattern (red = x, green = 0, blue = y).
module vga_timing_gen #(
  parameter int H_SYNC      = 192,
  parameter int H_BACK      = 304,
  parameter int H_ACTIVE    = 1600,
  parameter int H_FRONT     = 64,
  parameter int V_SYNC      = 3,
  parameter int V_BACK      = 46,
  parameter int V_ACTIVE    = 1200,
  parameter int V_FRONT     = 1,
  parameter int SYNC_ACTIVE = 0,
  parameter int PIX_LAT     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic        req_valid,
  output logic [15:0] req_x,
  output logic [15:0] req_y,
  input  logic [7:0]  pix_r,
  input  logic [7:0]  pix_g,
  input  logic [7:0]  pix_b,
  output logic [7:0]  r,
  output logic [7:0]  g,
  output logic [7:0]  b,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic        line_start,
  output logic        frame_start
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;

  if (H_TOTAL > 65535) begin : g_bad_h_total
    $error("vga_timing_gen: H_TOTAL exceeds 65535");
  end
  if (V_TOTAL > 65535) begin : g_bad_v_total
    $error("vga_timing_gen: V_TOTAL exceeds 65535");
  end
  if (PIX_LAT < 0 || PIX_LAT > 8) begin : g_bad_lat
    $error("vga_timing_gen: PIX_LAT must be within 0..8");
  end

  localparam logic [15:0] H_LAST = 16'(H_TOTAL - 1);
  localparam logic [15:0] V_LAST = 16'(V_TOTAL - 1);
  localparam logic [15:0] HS_END = 16'(H_SYNC);
  localparam logic [15:0] HDS    = 16'(H_SYNC + H_BACK);
  localparam logic [15:0] HA_END = 16'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [15:0] VS_END = 16'(V_SYNC);
  localparam logic [15:0] VDS    = 16'(V_SYNC + V_BACK);
  localparam logic [15:0] VA_END = 16'(V_SYNC + V_BACK + V_ACTIVE);
  localparam logic        SYNC_ACT = (SYNC_ACTIVE != 0);

  typedef enum logic [1:0] {PH_SYNC, PH_BACK, PH_ACTIVE, PH_FRONT} phase_t;

  typedef struct packed {
    logic hs;
    logic vs;
    logic act;
    logic ls;
    logic fs;
  } stage_t;

  localparam stage_t BLANK = '{hs: ~SYNC_ACT, vs: ~SYNC_ACT, act: 1'b0, ls: 1'b0, fs: 1'b0};

  logic [15:0] hcnt;
  logic [15:0] vcnt;
  phase_t      h_phase;
  phase_t      v_phase;
  stage_t      raw;
  stage_t      pipe [0:PIX_LAT];
  logic        act_lat;
  logic [23:0] src;

  // Raster counters; vcnt advances only on the hcnt wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (en) begin
      if (hcnt == H_LAST) begin
        hcnt <= '0;
        vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 16'd1;
      end else begin
        hcnt <= hcnt + 16'd1;
      end
    end
  end

  // Per-axis phase decode from the counters.
  always_comb begin
    h_phase = PH_FRONT;
    if (hcnt < HS_END)      h_phase = PH_SYNC;
    else if (hcnt < HDS)    h_phase = PH_BACK;
    else if (hcnt < HA_END) h_phase = PH_ACTIVE;
    v_phase = PH_FRONT;
    if (vcnt < VS_END)      v_phase = PH_SYNC;
    else if (vcnt < VDS)    v_phase = PH_BACK;
    else if (vcnt < VA_END) v_phase = PH_ACTIVE;
  end

  // Request-stage signals and coordinate requests.
  always_comb begin
    raw.hs    = (h_phase == PH_SYNC) ? SYNC_ACT : ~SYNC_ACT;
    raw.vs    = (v_phase == PH_SYNC) ? SYNC_ACT : ~SYNC_ACT;
    raw.act   = (h_phase == PH_ACTIVE) && (v_phase == PH_ACTIVE);
    raw.ls    = (hcnt == '0);
    raw.fs    = (hcnt == '0) && (vcnt == '0);
    req_valid = raw.act;
    req_x     = raw.act ? hcnt - HDS : '0;
    req_y     = raw.act ? vcnt - VDS : '0;
  end

  // Timing delay line of PIX_LAT+1 enabled stages; the last stage drives the outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i <= PIX_LAT; i++) pipe[i] <= BLANK;
    end else if (en) begin
      pipe[0] <= raw;
      for (int unsigned i = 1; i <= PIX_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign hsync       = pipe[PIX_LAT].hs;
  assign vsync       = pipe[PIX_LAT].vs;
  assign de          = pipe[PIX_LAT].act;
  assign line_start  = pipe[PIX_LAT].ls;
  assign frame_start = pipe[PIX_LAT].fs;

  // Active flag as it stood PIX_LAT cycles ago, i.e. when pix_* is due back.
  if (PIX_LAT == 0) begin : g_act_nolat
    assign act_lat = raw.act;
  end else begin : g_act_lat
    assign act_lat = pipe[PIX_LAT-1].act;
  end

`ifdef VGA_TEST_PATTERN_EN
  logic [23:0] pat;
  logic        unused_pix;
  assign pat        = {req_x[7:0], 8'h00, req_y[7:0]};
  assign unused_pix = ^{pix_r, pix_g, pix_b};

  if (PIX_LAT == 0) begin : g_pat_nolat
    assign src = pat;
  end else begin : g_pat_lat
    logic [23:0] pat_pipe [0:PIX_LAT-1];
    // Pattern delayed like an upstream source with PIX_LAT latency.
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int unsigned i = 0; i < PIX_LAT; i++) pat_pipe[i] <= '0;
      end else if (en) begin
        pat_pipe[0] <= pat;
        for (int unsigned i = 1; i < PIX_LAT; i++) pat_pipe[i] <= pat_pipe[i-1];
      end
    end
    assign src = pat_pipe[PIX_LAT-1];
  end
`else
  assign src = {pix_r, pix_g, pix_b};
`endif

  // RGB output register, blanked outside the active region.
  always_ff @(posedge clk) begin
    if (rst) begin
      {r, g, b} <= '0;
    end else if (en) begin
      {r, g, b} <= act_lat ? src : '0;
    end
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parameterised, synthesizable VGA raster timing generator that drives the `$vgasim` pixel sink (r, g, b, hsync, vsync, clk).
- Owns the horizontal and vertical counters and issues pixel-coordinate requests to an upstream pixel source.
- Accepts that source's RGB after a fixed latency.
- Emits RGB, sync and data-enable aligned to each other, replacing ad-hoc counter logic in simulation tops.

Parameters:
H_SYNC, 192, hsync pulse width in pixels
H_BACK, 304, horizontal back porch
H_ACTIVE, 1600, visible pixels per line
H_FRONT, 64, horizontal front porch
V_SYNC, 3, vsync pulse width in lines
V_BACK, 46, vertical back porch
V_ACTIVE, 1200, visible lines
V_FRONT, 1, vertical front porch
SYNC_ACTIVE, 0, level of hsync/vsync during the sync pulse (0 = active-low)
PIX_LAT, 2, cycles from request to pix_* valid (0..8)

Ports:
clk  in  1  pixel clock
rst  in  1  synchronous active-high reset
en  in  1  pixel-clock enable; 0 freezes all state
req_valid  out  1  coordinate request valid (active region)
req_x  out  16  requested column, 0..H_ACTIVE-1
req_y  out  16  requested row, 0..V_ACTIVE-1
pix_r  in  8  upstream red for the request issued PIX_LAT enabled cycles earlier
pix_g  in  8  upstream green
pix_b  in  8  upstream blue
r  out  8  red to sink
g  out  8  green to sink
b  out  8  blue to sink
hsync  out  1  horizontal sync
vsync  out  1  vertical sync
de  out  1  data enable, aligned with r/g/b
line_start  out  1  one-cycle pulse, aligned with output hcnt==0
frame_start  out  1  one-cycle pulse, aligned with output hcnt==0 && vcnt==0

Behaviour:
Clocking and reset:
- Single clock `clk`; `rst` is synchronous and active-high.
- Reset, applied at any time:
  - hcnt=0, vcnt=0.
  - All delay stages loaded with blank (de=0, sync at inactive level ~SYNC_ACTIVE, pulses 0).
  - Outputs: r=g=b=0, de=0, hsync=vsync=~SYNC_ACTIVE, line_start=frame_start=0, req_valid=0, req_x=req_y=0.
- Reset asserted mid-frame discards the frame; the first enabled cycle after release is hcnt=0, vcnt=0.

Counters:
- H_TOTAL = sum of the four H_* parameters; V_TOTAL = sum of the four V_*.
- Both totals must be ≤ 65535; otherwise `$error` at elaboration.
- On each cycle with en=1:
  - hcnt increments and wraps at H_TOTAL-1 → 0.
  - vcnt increments only on the hcnt wrap, wrapping at V_TOTAL-1 → 0.
  - A simultaneous wrap of both returns to (0,0) on the same edge.
- Per-axis phase FSM, decoded from the counters: SYNC [0,SYNC) → BACK → ACTIVE → FRONT → SYNC.
  - HDS = H_SYNC+H_BACK; VDS = V_SYNC+V_BACK.

Raw (request-stage) signals, combinational from the counters:
- hs_raw = SYNC_ACTIVE when hcnt<H_SYNC; vs_raw likewise for vcnt<V_SYNC.
- act = hcnt in [HDS, HDS+H_ACTIVE) && vcnt in [VDS, VDS+V_ACTIVE).
- req_valid = act; req_x = hcnt-HDS and req_y = vcnt-VDS when act, else 0.

Alignment pipeline:
- hs_raw, vs_raw, act and the start pulses pass through a delay line of PIX_LAT+1 enabled stages.
- pix_* is sampled on the enabled edge PIX_LAT cycles after its request and registered to r/g/b.
- Net latency from a request to the matching output: PIX_LAT+1 enabled cycles, identical for RGB and sync.
- With PIX_LAT=0, pix_* is sampled in the request cycle.

Blanking:
- r=g=b=0 whenever the delayed de=0, regardless of pix_*.

Stall:
- With en=0, counters, the delay line and all outputs hold their values.
- req_* hold, since they are derived from the counters.

Optional Feature:
VGA_TEST_PATTERN_EN
- Defined: pix_* are ignored. An internal pattern is delayed PIX_LAT cycles in place of the upstream data:
  - red = req_x[7:0]
  - green = 0
  - blue = req_y[7:0]
- Blanking and latency rules are unchanged. req_* outputs still toggle.
- Undefined: pix_* pass-through as specified above.

Test Plan:
Common setup: H=2/3/4/1 (H_TOTAL=10), V=1/1/2/1 (V_TOTAL=5), PIX_LAT=2, SYNC_ACTIVE=0, en=1.
1. Reset, then run 60 cycles → hsync=0 on outputs for hcnt 0-1 (3 cycles late); frame_start high once per 50 cycles, first one on cycle 3 after reset release.
2. Drive pix_r from req_x with a 2-cycle model delay → r sequence 0,1,2,3 with de=1 on line 2 (vcnt=2), 8 active pixels per frame; r=0 whenever de=0 even though pix_r is held at 0xFF.
3. Toggle en=0 for 7 cycles mid-active → all outputs and req_x frozen; resumes with no dropped or duplicated pixel (pixel count per frame = 8).
4. Assert rst for 1 cycle at vcnt=3, hcnt=6 → next cycle outputs are at reset values; req_x/req_y=0; next frame_start after 3 cycles.
5. Wrap check: at hcnt=9, vcnt=4 → next enabled edge gives hcnt=0, vcnt=0; frame_start and line_start coincide at the output.
6. Build with VGA_TEST_PATTERN_EN, pix_* tied to 0xAA → r=req_x, b=req_y, g=0 during de; 0 elsewhere.
